// File: rtl/rv32i_rf_pkg.sv
// Shared types and constants for the rv32i register-file controller.
package rv32i_rf_pkg;

    localparam int unsigned RF_AW         = 5;
    localparam int unsigned RF_XLEN       = 32;
    localparam int unsigned RF_FIRST_INIT = 1;
    localparam int unsigned RF_LAST_INIT  = 31;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        HALTING,
        HALTED
    } rf_ctrl_state_e;

endpackage

// File: rtl/rv32i_regfile_ctrl.sv
// Register-file port sequencer: zero-init after reset, core passthrough in run mode,
// and single-register debug access once the core has drained on a halt request.
module rv32i_regfile_ctrl
    import rv32i_rf_pkg::*;
#(
    parameter int unsigned XLEN = RF_XLEN,
    parameter int unsigned AW   = RF_AW
) (
    input  logic            clk,
    input  logic            reset,
    output logic            init_done,
    input  logic            core_halt_req,
    output logic            core_halted,
    input  logic [AW-1:0]   core_rs1_addr,
    input  logic [AW-1:0]   core_rs2_addr,
    input  logic            core_rs1_en,
    input  logic            core_rs2_en,
    input  logic            core_rs1_clr,
    input  logic            core_rs2_clr,
    input  logic [AW-1:0]   core_wb_addr,
    input  logic [XLEN-1:0] core_wb_data,
    input  logic            core_wb_en,
    input  logic            dbg_req_valid,
    output logic            dbg_req_ready,
    input  logic            dbg_req_write,
    input  logic [AW-1:0]   dbg_req_addr,
    input  logic [XLEN-1:0] dbg_req_wdata,
    output logic            dbg_rsp_valid,
    output logic [XLEN-1:0] dbg_rsp_rdata,
    output logic [AW-1:0]   rf_read_register_1,
    output logic [AW-1:0]   rf_read_register_2,
    output logic            rf_read_enable_1,
    output logic            rf_read_enable_2,
    output logic            rf_read_clear_1,
    output logic            rf_read_clear_2,
    output logic [AW-1:0]   rf_write_register,
    output logic [XLEN-1:0] rf_write_data,
    output logic            rf_write_enable,
    input  logic [XLEN-1:0] rf_read_data_1
);

    rf_ctrl_state_e state;
    rf_ctrl_state_e state_nxt;
    logic [AW-1:0]  idx;
    logic           rd_pending;
    logic           leave_clr;
    logic           dbg_acc_wr;
    logic           dbg_acc_rd;

    // Debug owns the ports only when halted; one read outstanding at a time.
    always_comb begin
        dbg_req_ready = (state == HALTED) && !rd_pending;
        dbg_acc_wr    = dbg_req_valid && dbg_req_ready && dbg_req_write;
        dbg_acc_rd    = dbg_req_valid && dbg_req_ready && !dbg_req_write;
    end

    // Next-state and register-file port muxing.
    always_comb begin
        state_nxt          = state;
        rf_read_register_1 = core_rs1_addr;
        rf_read_register_2 = core_rs2_addr;
        rf_read_enable_1   = core_rs1_en;
        rf_read_enable_2   = core_rs2_en;
        rf_read_clear_1    = core_rs1_clr || leave_clr;
        rf_read_clear_2    = core_rs2_clr || leave_clr;
        rf_write_register  = core_wb_addr;
        rf_write_data      = core_wb_data;
        rf_write_enable    = core_wb_en && (core_wb_addr != '0);

        case (state)
            INIT: begin
                rf_read_enable_1  = 1'b0;
                rf_read_enable_2  = 1'b0;
                rf_read_clear_1   = 1'b1;
                rf_read_clear_2   = 1'b1;
                rf_write_register = idx;
                rf_write_data     = '0;
                rf_write_enable   = 1'b1;
                if (idx == AW'(RF_LAST_INIT)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (core_halt_req) begin
                    state_nxt = HALTING;
                end
            end
            HALTING: begin
                // Keep passing writeback through until the pipe shows a quiet cycle.
                if (!core_halt_req) begin
                    state_nxt = RUN;
                end else if (!core_wb_en) begin
                    state_nxt = HALTED;
                end
            end
            HALTED: begin
                rf_read_register_1 = dbg_req_addr;
                rf_read_enable_1   = dbg_acc_rd;
                rf_read_clear_1    = 1'b0;
                rf_read_register_2 = '0;
                rf_read_enable_2   = 1'b0;
                rf_read_clear_2    = 1'b0;
                rf_write_register  = dbg_req_addr;
                rf_write_data      = dbg_req_wdata;
                rf_write_enable    = dbg_acc_wr && (dbg_req_addr != '0);
                if (!core_halt_req && !rd_pending) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    // State, init index, status flags and debug read response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= INIT;
            idx           <= AW'(RF_FIRST_INIT);
            init_done     <= 1'b0;
            core_halted   <= 1'b0;
            dbg_rsp_valid <= 1'b0;
            dbg_rsp_rdata <= '0;
            rd_pending    <= 1'b0;
            leave_clr     <= 1'b0;
        end else begin
            state         <= state_nxt;
            core_halted   <= (state_nxt == HALTED);
            leave_clr     <= (state == HALTED) && (state_nxt == RUN);
            rd_pending    <= dbg_acc_rd;
            dbg_rsp_valid <= dbg_acc_rd;
            if (state == INIT) begin
                idx <= idx + AW'(1);
            end
            if ((state == INIT) && (state_nxt == RUN)) begin
                init_done <= 1'b1;
            end
            if (dbg_acc_rd) begin
                dbg_rsp_rdata <= rf_read_data_1;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_regfile_ctrl.sv
// Scoreboarded bench for rv32i_regfile_ctrl with a behavioural register file and reference model.
module tb_rv32i_regfile_ctrl;

    localparam int unsigned AW   = 5;
    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            init_done;
    logic            core_halt_req = 1'b0;
    logic            core_halted;
    logic [AW-1:0]   core_rs1_addr = '0;
    logic [AW-1:0]   core_rs2_addr = '0;
    logic            core_rs1_en = 1'b0;
    logic            core_rs2_en = 1'b0;
    logic            core_rs1_clr = 1'b0;
    logic            core_rs2_clr = 1'b0;
    logic [AW-1:0]   core_wb_addr = '0;
    logic [XLEN-1:0] core_wb_data = '0;
    logic            core_wb_en = 1'b0;
    logic            dbg_req_valid = 1'b0;
    logic            dbg_req_ready;
    logic            dbg_req_write = 1'b0;
    logic [AW-1:0]   dbg_req_addr = '0;
    logic [XLEN-1:0] dbg_req_wdata = '0;
    logic            dbg_rsp_valid;
    logic [XLEN-1:0] dbg_rsp_rdata;
    logic [AW-1:0]   rf_read_register_1;
    logic [AW-1:0]   rf_read_register_2;
    logic            rf_read_enable_1;
    logic            rf_read_enable_2;
    logic            rf_read_clear_1;
    logic            rf_read_clear_2;
    logic [AW-1:0]   rf_write_register;
    logic [XLEN-1:0] rf_write_data;
    logic            rf_write_enable;
    logic [XLEN-1:0] rf_read_data_1;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wr_t;

    typedef struct {
        logic [XLEN-1:0] data;
        int              cyc;
    } rsp_t;

    wr_t             wq[$];
    rsp_t            rq[$];
    logic [XLEN-1:0] ref_regs [32];
    logic [XLEN-1:0] mem [32];
    logic            scramble = 1'b1;
    int              total = 0;
    int              bad = 0;
    int              cyc = 0;

    rv32i_regfile_ctrl #(.XLEN(XLEN), .AW(AW)) dut (
        .clk(clk), .reset(reset), .init_done(init_done),
        .core_halt_req(core_halt_req), .core_halted(core_halted),
        .core_rs1_addr(core_rs1_addr), .core_rs2_addr(core_rs2_addr),
        .core_rs1_en(core_rs1_en), .core_rs2_en(core_rs2_en),
        .core_rs1_clr(core_rs1_clr), .core_rs2_clr(core_rs2_clr),
        .core_wb_addr(core_wb_addr), .core_wb_data(core_wb_data), .core_wb_en(core_wb_en),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
        .dbg_req_write(dbg_req_write), .dbg_req_addr(dbg_req_addr),
        .dbg_req_wdata(dbg_req_wdata), .dbg_rsp_valid(dbg_rsp_valid),
        .dbg_rsp_rdata(dbg_rsp_rdata),
        .rf_read_register_1(rf_read_register_1), .rf_read_register_2(rf_read_register_2),
        .rf_read_enable_1(rf_read_enable_1), .rf_read_enable_2(rf_read_enable_2),
        .rf_read_clear_1(rf_read_clear_1), .rf_read_clear_2(rf_read_clear_2),
        .rf_write_register(rf_write_register), .rf_write_data(rf_write_data),
        .rf_write_enable(rf_write_enable), .rf_read_data_1(rf_read_data_1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file stand-in: garbage at power-up, combinational read, x0 reads as zero.
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < 32; i++) mem[i] <= $urandom();
        end else if (rf_write_enable === 1'b1) begin
            mem[rf_write_register] <= rf_write_data;
        end
    end

    always_comb rf_read_data_1 = (rf_read_register_1 == '0) ? '0 : mem[rf_read_register_1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every register-file write and every debug response is matched against the queues.
    always @(negedge clk) begin : monitor
        wr_t  we;
        rsp_t re;
        if (reset !== 1'b1 && rf_write_enable === 1'b1) begin
            if (wq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rf_write: addr %0d data %h, none expected (cycle %0d)",
                         rf_write_register, rf_write_data, cyc);
            end else begin
                we = wq.pop_front();
                chk("rf_write_addr", 32'(rf_write_register), 32'(we.addr));
                chk("rf_write_data", rf_write_data, we.data);
            end
        end
        if (dbg_rsp_valid === 1'b1) begin
            if (rq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_dbg_rsp: rdata %h, none expected (cycle %0d)",
                         dbg_rsp_rdata, cyc);
            end else begin
                re = rq.pop_front();
                chk("dbg_rsp_rdata", dbg_rsp_rdata, re.data);
                chk("dbg_rsp_cycle", 32'(cyc), 32'(re.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset n cycles; afterwards the model expects x1..x31 zeroed in order.
    task automatic do_reset(input int n);
        reset = 1'b1;
        wq.delete();
        rq.delete();
        repeat (n) tick();
        dbg_req_valid = 1'b0;
        core_halt_req = 1'b0;
        core_wb_en    = 1'b0;
        reset = 1'b0;
        for (int i = 1; i < 32; i++) begin
            wq.push_back('{5'(i), 32'd0});
            ref_regs[i] = '0;
        end
    endtask

    task automatic init_check();
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (i <= 31) begin
                chk("init_done_low", 32'(init_done), 32'd0);
                chk("init_read_ctl", 32'({rf_read_enable_1, rf_read_enable_2,
                                          rf_read_clear_1, rf_read_clear_2}), 32'h3);
            end else begin
                chk("init_done_rise", 32'(init_done), 32'd1);
            end
        end
        chk("init_writes_drained", 32'(wq.size()), 32'd0);
        tick();
    endtask

    task automatic dbg_op(input bit wr, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        bit acc = 1'b0;
        dbg_req_valid = 1'b1;
        dbg_req_write = wr;
        dbg_req_addr  = a;
        dbg_req_wdata = d;
        for (int k = 0; k < 8 && !acc; k++) begin
            #1;
            if (dbg_req_ready === 1'b1) begin
                acc = 1'b1;
                if (wr) begin
                    if (a != '0) begin
                        wq.push_back('{a, d});
                        ref_regs[a] = d;
                    end
                end else begin
                    rq.push_back('{(a == '0) ? 32'd0 : ref_regs[a], cyc + 1});
                end
            end
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL dbg_req_ready_timeout: ready stayed %b, required 1 (addr %0d)",
                     dbg_req_ready, a);
        end
    endtask

    task automatic core_read_all(input string name);
        for (int i = 0; i < 32; i++) begin
            core_rs1_addr = 5'(i);
            core_rs1_en   = 1'b1;
            @(negedge clk);
            chk(name, rf_read_data_1, ref_regs[i]);
            tick();
        end
        core_rs1_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        logic [AW-1:0] a;
        logic [XLEN-1:0] d;
        for (int i = 0; i < 32; i++) ref_regs[i] = '0;

        // Power-up reset and reset-state checks.
        tick();
        scramble = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_core_halted", 32'(core_halted), 32'd0);
        chk("rst_dbg_req_ready", 32'(dbg_req_ready), 32'd0);
        chk("rst_dbg_rsp_valid", 32'(dbg_rsp_valid), 32'd0);
        chk("rst_dbg_rsp_rdata", dbg_rsp_rdata, 32'd0);
        chk("rst_init_idx", 32'(rf_write_register), 32'd1);
        tick();
        do_reset(1);

        // Reset in the middle of initialisation restarts from x1.
        repeat (9) tick();
        chk("init_idx_before_reset", 32'(rf_write_register), 32'd10);
        do_reset(2);
        init_check();

        // Core reads of freshly initialised registers.
        core_rs1_addr = 5'd5; core_rs1_en = 1'b1;
        core_rs2_addr = 5'd9; core_rs2_en = 1'b1;
        @(negedge clk);
        chk("core_rd_x5_addr", 32'(rf_read_register_1), 32'd5);
        chk("core_rd_x5_en", 32'(rf_read_enable_1), 32'd1);
        chk("core_rd_x5_data", rf_read_data_1, 32'd0);
        chk("core_rd2_addr", 32'(rf_read_register_2), 32'd9);
        tick();
        core_rs1_en = 1'b0; core_rs2_en = 1'b0;

        // Writeback to x3 passes, writeback to x0 is suppressed.
        core_wb_en = 1'b1; core_wb_addr = 5'd3; core_wb_data = 32'hDEAD_BEEF;
        wq.push_back('{5'd3, 32'hDEAD_BEEF});
        ref_regs[3] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("run_wb_x3_en", 32'(rf_write_enable), 32'd1);
        tick();
        core_wb_addr = 5'd0; core_wb_data = 32'hCAFE_F00D;
        @(negedge clk);
        chk("run_wb_x0_en", 32'(rf_write_enable), 32'd0);
        tick();
        core_wb_en = 1'b0;

        // Randomised run-mode traffic.
        for (int i = 0; i < 30; i++) begin
            core_rs1_addr = 5'($urandom); core_rs2_addr = 5'($urandom);
            core_rs1_en = 1'($urandom); core_rs2_en = 1'($urandom);
            core_rs1_clr = 1'($urandom); core_rs2_clr = 1'($urandom);
            core_wb_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            core_wb_data = $urandom();
            core_wb_en = 1'($urandom);
            if (core_wb_en && core_wb_addr != '0) begin
                wq.push_back('{core_wb_addr, core_wb_data});
                ref_regs[core_wb_addr] = core_wb_data;
            end
            @(negedge clk);
            chk("run_read_passthrough",
                32'({rf_read_register_1, rf_read_enable_1, rf_read_clear_1,
                     rf_read_register_2, rf_read_enable_2, rf_read_clear_2}),
                32'({core_rs1_addr, core_rs1_en, core_rs1_clr,
                     core_rs2_addr, core_rs2_en, core_rs2_clr}));
            tick();
        end
        core_wb_en = 1'b0; core_rs1_clr = 1'b0; core_rs2_clr = 1'b0;
        core_rs1_en = 1'b0; core_rs2_en = 1'b0;

        // Halt while two writebacks are in flight; both must land before debug takes over.
        core_halt_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            core_wb_en = 1'b1;
            core_wb_addr = 5'($urandom_range(1, 31));
            core_wb_data = $urandom();
            wq.push_back('{core_wb_addr, core_wb_data});
            ref_regs[core_wb_addr] = core_wb_data;
            @(negedge clk);
            chk("drain_not_halted", 32'(core_halted), 32'd0);
            tick();
        end
        core_wb_en = 1'b0;
        @(negedge clk);
        chk("quiet_not_halted", 32'(core_halted), 32'd0);
        tick();
        // Core traffic while halted must be ignored.
        core_wb_en = 1'b1; core_wb_addr = 5'd5; core_wb_data = 32'h5555_AAAA;
        core_rs2_en = 1'b1; core_rs2_clr = 1'b1;
        @(negedge clk);
        chk("halted_set", 32'(core_halted), 32'd1);
        chk("halted_ready", 32'(dbg_req_ready), 32'd1);
        chk("halted_rd2_ctl", 32'({rf_read_enable_2, rf_read_clear_2}), 32'd0);
        tick();

        // Debug write then back-to-back read of x7.
        dbg_op(1'b1, 5'd7, 32'h1234_5678);
        dbg_op(1'b0, 5'd7, 32'd0);
        dbg_req_valid = 1'b0;
        #1;
        chk("pending_ready_low", 32'(dbg_req_ready), 32'd0);
        tick();

        // x0 ignores writes and reads as zero.
        dbg_op(1'b1, 5'd0, 32'hFFFF_FFFF);
        dbg_op(1'b0, 5'd0, 32'd0);
        dbg_req_valid = 1'b0;
        tick();

        // Randomised debug traffic.
        for (int i = 0; i < 24; i++) begin
            a = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            d = $urandom();
            dbg_op(1'($urandom), a, d);
            if ($urandom_range(0, 3) == 0) begin
                dbg_req_valid = 1'b0;
                tick();
            end
        end
        dbg_req_valid = 1'b0;
        core_wb_en = 1'b0; core_rs2_en = 1'b0; core_rs2_clr = 1'b0;
        tick();
        tick();

        // Drop halt with a read outstanding: response first, then run with a one-cycle read clear.
        dbg_op(1'b0, 5'd7, 32'd0);
        dbg_req_valid = 1'b0;
        core_halt_req = 1'b0;
        k = -1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (core_halted === 1'b0) begin
                k = j;
                break;
            end
        end
        chk("halt_exit_cycles", 32'(k), 32'd2);
        chk("exit_read_clear", 32'({rf_read_clear_1, rf_read_clear_2}), 32'h3);
        @(negedge clk);
        chk("exit_clear_once", 32'({rf_read_clear_1, rf_read_clear_2}), 32'h0);
        chk("run_ready_low", 32'(dbg_req_ready), 32'd0);
        tick();
        chk("rsp_queue_empty", 32'(rq.size()), 32'd0);

        // Every register as seen from the core matches the model.
        core_read_all("core_readback");

        // Reset while halted with a read being accepted: no response may follow.
        core_halt_req = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (core_halted === 1'b1) break;
        end
        chk("rehalt", 32'(core_halted), 32'd1);
        @(posedge clk);
        #1;
        dbg_req_valid = 1'b1; dbg_req_write = 1'b0; dbg_req_addr = 5'd7;
        do_reset(3);
        init_check();
        core_read_all("post_reset_zero");
        repeat (3) tick();
        chk("final_wq_empty", 32'(wq.size()), 32'd0);
        chk("final_rq_empty", 32'(rq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
